// File: rtl/fetch_queue_unit_if.sv
// fetch_queue_unit_if: instruction-memory, redirect and decode handshake bundle for the fetch stage
interface fetch_queue_unit_if #(parameter int ADDR_W = 32);
  logic              fetch_en;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_re;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              id_valid;
  logic [31:0]       id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic              id_ready;
  modport master (
    input  fetch_en, imem_rdata, redirect_valid, redirect_pc, id_ready,
    output imem_addr, imem_re, id_valid, id_instr, id_pc
  );
  modport slave (
    output fetch_en, imem_rdata, redirect_valid, redirect_pc, id_ready,
    input  imem_addr, imem_re, id_valid, id_instr, id_pc
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: PC owner feeding a small {instr, pc} FIFO toward decode, flushed by redirects
module fetch_queue_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                QDEPTH   = 2
) (
  input logic clk,
  input logic rst_n,
  fetch_queue_unit_if.master fq
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [31:0]       instr_q [QDEPTH];
  logic [31:0]       instr_d [QDEPTH];
  logic [ADDR_W-1:0] epc_q [QDEPTH];
  logic [ADDR_W-1:0] epc_d [QDEPTH];
  logic deq, fire;
  assign deq  = fq.id_valid & fq.id_ready;
  // a dequeue frees a slot in the same cycle, so a full queue still fetches
  assign fire = rst_n & fq.fetch_en & ~fq.redirect_valid & ((count_q < FULL) | deq);
  assign fq.imem_re   = fire;
  assign fq.imem_addr = pc_q;
  assign fq.id_valid  = count_q != '0;
  assign fq.id_instr  = instr_q[head_q];
  assign fq.id_pc     = epc_q[head_q];
  always_comb begin
    pc_d    = fq.redirect_valid ? fq.redirect_pc : fire ? pc_q + ADDR_W'(1) : pc_q;
    head_d  = fq.redirect_valid ? '0 : deq ? head_q + PW'(1) : head_q;
    tail_d  = fq.redirect_valid ? '0 : fire ? tail_q + PW'(1) : tail_q;
    count_d = fq.redirect_valid ? '0 :
              (fire & ~deq) ? count_q + CW'(1) :
              (deq & ~fire) ? count_q - CW'(1) : count_q;
    instr_d = instr_q;
    epc_d   = epc_q;
    if (fire) begin
      instr_d[tail_q] = fq.imem_rdata;
      epc_d[tail_q]   = pc_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      instr_q <= '{default: '0};
      epc_q   <= '{default: '0};
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      instr_q <= instr_d;
      epc_q   <= epc_d;
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed vector table plus reset and PC-wrap sequences for fetch_queue_unit
module tb_fetch_queue_unit;
  localparam bit T = 1'b1;
  localparam bit F = 1'b0;
  typedef struct {
    bit fe, rdy, rv;
    logic [31:0] rpc;
    bit ev;
    logic [31:0] epc;
    bit re;
    logic [31:0] eaddr;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  vec_t tbl [24];
  fetch_queue_unit_if #(.ADDR_W(32)) if0 ();
  fetch_queue_unit_if #(.ADDR_W(8))  if1 ();
  fetch_queue_unit #(.ADDR_W(32), .RESET_PC(32'd0), .QDEPTH(2)) u0 (.clk(clk), .rst_n(rst_n), .fq(if0));
  fetch_queue_unit #(.ADDR_W(8), .RESET_PC(8'hFE), .QDEPTH(2)) u1 (.clk(clk), .rst_n(rst_n), .fq(if1));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'd0  ? 32'h0030_2083 :
           a == 32'd1  ? 32'h0030_2103 :
           a == 32'd21 ? 32'h0021_05B3 : (32'hA500_0000 | a);
  endfunction
  assign if0.imem_rdata = mem(if0.imem_addr);
  assign if1.imem_rdata = mem({24'd0, if1.imem_addr});
  function automatic vec_t v(bit fe, bit rdy, bit rv, int rpc, bit ev, int epc, bit re, int eaddr);
    vec_t r;
    r.fe = fe; r.rdy = rdy; r.rv = rv; r.rpc = rpc;
    r.ev = ev; r.epc = epc; r.re = re; r.eaddr = eaddr;
    return r;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  initial begin
    tbl[0]  = v(T,F,F,0,   F,0,  T,0);
    tbl[1]  = v(T,F,F,0,   T,0,  T,1);
    tbl[2]  = v(T,F,F,0,   T,0,  F,2);
    tbl[3]  = v(T,F,F,0,   T,0,  F,2);
    tbl[4]  = v(T,T,F,0,   T,0,  T,2);
    tbl[5]  = v(T,T,F,0,   T,1,  T,3);
    tbl[6]  = v(T,T,F,0,   T,2,  T,4);
    tbl[7]  = v(T,T,F,0,   T,3,  T,5);
    tbl[8]  = v(F,T,F,0,   T,4,  F,6);
    tbl[9]  = v(T,F,F,0,   T,5,  T,6);
    tbl[10] = v(T,F,T,21,  T,5,  F,7);
    tbl[11] = v(T,T,F,0,   F,0,  T,21);
    tbl[12] = v(T,T,F,0,   T,21, T,22);
    tbl[13] = v(T,T,F,0,   T,22, T,23);
    tbl[14] = v(T,F,F,0,   T,23, T,24);
    tbl[15] = v(T,T,T,40,  T,23, F,25);
    tbl[16] = v(T,T,F,0,   F,0,  T,40);
    tbl[17] = v(T,T,F,0,   T,40, T,41);
    tbl[18] = v(T,T,T,100, T,41, F,42);
    tbl[19] = v(T,T,T,7,   F,0,  F,100);
    tbl[20] = v(T,T,F,0,   F,0,  T,7);
    tbl[21] = v(T,T,F,0,   T,7,  T,8);
    tbl[22] = v(F,T,F,0,   T,8,  F,9);
    tbl[23] = v(F,T,F,0,   F,0,  F,9);
    if0.fetch_en = 1'b1; if0.id_ready = 1'b0; if0.redirect_valid = 1'b0; if0.redirect_pc = '0;
    if1.fetch_en = 1'b1; if1.id_ready = 1'b1; if1.redirect_valid = 1'b0; if1.redirect_pc = '0;
    #1;
    chk("rst id_valid", 64'(if0.id_valid), 64'd0);
    chk("rst imem_re", 64'(if0.imem_re), 64'd0);
    chk("rst imem_addr", 64'(if0.imem_addr), 64'd0);
    chk("rst id_instr", 64'(if0.id_instr), 64'd0);
    chk("rst id_pc", 64'(if0.id_pc), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if0.fetch_en = tbl[i].fe;
      if0.id_ready = tbl[i].rdy;
      if0.redirect_valid = tbl[i].rv;
      if0.redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("row%0d id_valid", i), 64'(if0.id_valid), 64'(tbl[i].ev));
      chk($sformatf("row%0d imem_re", i), 64'(if0.imem_re), 64'(tbl[i].re));
      chk($sformatf("row%0d imem_addr", i), 64'(if0.imem_addr), 64'(tbl[i].eaddr));
      if (tbl[i].ev) begin
        chk($sformatf("row%0d id_pc", i), 64'(if0.id_pc), 64'(tbl[i].epc));
        chk($sformatf("row%0d id_instr", i), 64'(if0.id_instr), 64'(mem(tbl[i].epc)));
      end
      @(posedge clk); #1;
    end
    if0.fetch_en = 1'b1; if0.id_ready = 1'b0; if0.redirect_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("full id_valid", 64'(if0.id_valid), 64'd1);
    chk("full id_pc", 64'(if0.id_pc), 64'd9);
    chk("full imem_re", 64'(if0.imem_re), 64'd0);
    chk("full imem_addr", 64'(if0.imem_addr), 64'd11);
    #2 rst_n = 1'b0;
    #1;
    chk("async id_valid", 64'(if0.id_valid), 64'd0);
    chk("async imem_re", 64'(if0.imem_re), 64'd0);
    chk("async imem_addr", 64'(if0.imem_addr), 64'd0);
    chk("async id_pc", 64'(if0.id_pc), 64'd0);
    chk("async id_instr", 64'(if0.id_instr), 64'd0);
    chk("async wrap id_valid", 64'(if1.id_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    if0.id_ready = 1'b1;
    #1;
    chk("rel imem_re", 64'(if0.imem_re), 64'd1);
    chk("rel imem_addr", 64'(if0.imem_addr), 64'd0);
    chk("rel id_valid", 64'(if0.id_valid), 64'd0);
    chk("wrap imem_addr", 64'(if1.imem_addr), 64'hFE);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] wpc;
      wpc = 8'hFE + 8'(k);
      @(posedge clk); #1;
      chk($sformatf("rel%0d id_valid", k), 64'(if0.id_valid), 64'd1);
      chk($sformatf("rel%0d id_pc", k), 64'(if0.id_pc), 64'(k));
      chk($sformatf("rel%0d id_instr", k), 64'(if0.id_instr), 64'(mem(32'(k))));
      chk($sformatf("wrap%0d id_valid", k), 64'(if1.id_valid), 64'd1);
      chk($sformatf("wrap%0d id_pc", k), 64'(if1.id_pc), 64'(wpc));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
